// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision add/sub sequencer: field widths,
// special encodings, FSM state codes and FLAGS bit positions.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int XMANT_W = FRAC_W + 4;
  localparam int BIAS    = 15;

  // Smallest biased exponent that no longer encodes a finite value.
  localparam logic [EXP_W:0] EXP_OVF = 6'(2 * BIAS + 1);

  localparam logic [15:0] QNAN = 16'h7E00;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int F_INVALID = 4;
  localparam int F_ZERO    = 3;
  localparam int F_UF      = 2;
  localparam int F_OF      = 1;
  localparam int F_INEXACT = 0;

  // Subnormals are recognisable downstream by a clear hidden bit on a non-zero value.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational fp16 operand unpack: sign, class, effective exponent and the
// extended mantissa {hidden, frac, G, R, S}.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]        op,
  output logic               sign,
  output fp_class_t          cls,
  output logic [EXP_W-1:0]   exp,
  output logic [XMANT_W-1:0] xmant
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic              e_zero;
  logic              e_max;

  assign e      = op[14:10];
  assign f      = op[9:0];
  assign e_zero = (e == '0);
  assign e_max  = (e == '1);

  always_comb begin
    sign        = op[15];
    cls.is_zero = e_zero & (f == '0);
    cls.is_inf  = e_max & (f == '0);
    cls.is_nan  = e_max & (f != '0);
    // Subnormals share the scale of exponent 1, they just lack the hidden bit.
    exp         = e_zero ? 5'd1 : e;
    xmant       = {~e_zero, f, 3'b000};
  end

endmodule

// File: rtl/fp16_add_seq.sv
// Multi-cycle fp16 add/sub: unpack, iterative align with sticky, add,
// iterative normalize and round-to-nearest-even behind valid/ready handshakes.
module fp16_add_seq
  import fp16_pkg::*;
#(
  parameter int ALIGN_FAST = 14
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_A,
  input  logic [15:0] IN_B,
  input  logic        IN_SUB,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic [4:0]  FLAGS
);

  localparam logic [EXP_W-1:0] AF = EXP_W'(ALIGN_FAST);

  logic [2:0]         state, state_nxt;
  logic               idle_q;
  logic               accept;
  logic [15:0]        a_raw, b_raw, b_eff;
  logic               sub_r;
  logic               sa, sb;
  fp_class_t          ca, cb;
  logic [EXP_W-1:0]   ea, eb;
  logic [XMANT_W-1:0] xa, xb;
  logic               swap;
  logic               lg_sign;
  logic [EXP_W-1:0]   lg_exp, sm_exp;
  logic [XMANT_W-1:0] lg_xm, sm_xm;
  logic               nan_res, is_special;
  logic [15:0]        special_q;
  logic [4:0]         special_f;
  logic               sign_r, eff_sub_r, negz_r;
  logic [EXP_W:0]     exp_r;
  logic [EXP_W-1:0]   d_r;
  logic [XMANT_W-1:0] ma_r, mb_r;
  logic [XMANT_W:0]   nm_r, sum;
  logic               align_done, norm_shift, norm_last;
  logic [20:0]        rnd;
  logic [15:0]        q_r;
  logic [4:0]         flags_r;

  // Round-to-nearest-even and final packing; returns {flags, q}.
  function automatic logic [20:0] round_pack(input logic [XMANT_W-1:0] nm,
                                             input logic [EXP_W:0]     e,
                                             input logic               sign,
                                             input logic               neg_zero);
    logic [FRAC_W:0]   m;
    logic              g, r, s, inexact, inc;
    logic [FRAC_W+1:0] mr;
    logic [EXP_W:0]    e_out;
    logic [4:0]        fl;
    logic [15:0]       q;
    m       = nm[XMANT_W-1:3];
    g       = nm[2];
    r       = nm[1];
    s       = nm[0];
    inexact = g | r | s;
    inc     = g & (r | s | m[0]);
    mr      = {1'b0, m} + {{(FRAC_W + 1){1'b0}}, inc};
    e_out   = mr[FRAC_W+1] ? e + 6'd1 : e;
    fl      = '0;
    if (nm == '0) begin
      q           = {neg_zero, 15'h0000};
      fl[F_ZERO]  = 1'b1;
    end else if (e_out >= EXP_OVF) begin
      q             = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      fl[F_OF]      = 1'b1;
      fl[F_INEXACT] = 1'b1;
    end else begin
      q = {sign,
           (mr[FRAC_W+1] | mr[FRAC_W]) ? e_out[EXP_W-1:0] : {EXP_W{1'b0}},
           mr[FRAC_W+1] ? {FRAC_W{1'b0}} : mr[FRAC_W-1:0]};
      fl[F_INEXACT] = inexact;
      fl[F_UF]      = inexact & ~nm[XMANT_W-1];
    end
    return {fl, q};
  endfunction

  assign accept = IN_VALID & idle_q;
  assign b_eff  = {b_raw[15] ^ sub_r, b_raw[14:0]};

  fp16_unpack u_unpack_a (.op(a_raw), .sign(sa), .cls(ca), .exp(ea), .xmant(xa));
  fp16_unpack u_unpack_b (.op(b_eff), .sign(sb), .cls(cb), .exp(eb), .xmant(xb));

  always_comb begin
    swap       = (b_eff[14:0] > a_raw[14:0]);
    lg_sign    = swap ? sb : sa;
    lg_exp     = swap ? eb : ea;
    sm_exp     = swap ? ea : eb;
    lg_xm      = swap ? xb : xa;
    sm_xm      = swap ? xa : xb;
    nan_res    = ca.is_nan | cb.is_nan | (ca.is_inf & cb.is_inf & (sa ^ sb));
    is_special = ca.is_nan | cb.is_nan | ca.is_inf | cb.is_inf;
    special_q  = nan_res ? QNAN : {ca.is_inf ? sa : sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    special_f  = '0;
    special_f[F_INVALID] = nan_res;
  end

  always_comb begin
    sum = eff_sub_r ? ({1'b0, ma_r} - {1'b0, mb_r}) : ({1'b0, ma_r} + {1'b0, mb_r});
    align_done = (d_r <= 5'd1) | (d_r >= AF);
    norm_shift = ~nm_r[XMANT_W] & ~nm_r[XMANT_W-1] & (|nm_r) & (exp_r > 6'd1);
    norm_last  = nm_r[XMANT_W-2] | (exp_r == 6'd2);
    rnd        = round_pack(nm_r[XMANT_W-1:0], exp_r, sign_r, negz_r);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = is_special ? S_DONE : S_ALIGN;
      S_ALIGN:  if (align_done) state_nxt = S_ADD;
      S_ADD:    state_nxt = S_NORM;
      S_NORM:   state_nxt = (norm_shift && !norm_last) ? S_NORM : S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   if (OUT_READY) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      idle_q  <= 1'b0;
      q_r     <= '0;
      flags_r <= '0;
    end else begin
      state  <= state_nxt;
      idle_q <= (state_nxt == S_IDLE);
      if (state == S_UNPACK && is_special) begin
        q_r     <= special_q;
        flags_r <= special_f;
      end else if (state == S_ROUND) begin
        q_r     <= rnd[15:0];
        flags_r <= rnd[20:16];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_raw <= IN_A;
      b_raw <= IN_B;
      sub_r <= IN_SUB;
    end
    case (state)
      S_UNPACK: begin
        sign_r    <= lg_sign;
        eff_sub_r <= sa ^ sb;
        negz_r    <= ca.is_zero & cb.is_zero & sa & sb;
        exp_r     <= {1'b0, lg_exp};
        d_r       <= lg_exp - sm_exp;
        ma_r      <= lg_xm;
        mb_r      <= sm_xm;
      end
      S_ALIGN: begin
        if (d_r >= AF) begin
          mb_r <= {{(XMANT_W - 1){1'b0}}, |mb_r};
          d_r  <= '0;
        end else if (d_r != '0) begin
          mb_r <= {1'b0, mb_r[XMANT_W-1:2], |mb_r[1:0]};
          d_r  <= d_r - 5'd1;
        end
      end
      S_ADD: nm_r <= sum;
      S_NORM: begin
        if (nm_r[XMANT_W]) begin
          nm_r  <= {1'b0, nm_r[XMANT_W:2], |nm_r[1:0]};
          exp_r <= exp_r + 6'd1;
        end else if (norm_shift) begin
          nm_r  <= {nm_r[XMANT_W-1:0], 1'b0};
          exp_r <= exp_r - 6'd1;
        end
      end
      default: ;
    endcase
  end

  assign IN_READY  = idle_q;
  assign OUT_VALID = (state == S_DONE);
  assign Q         = q_r;
  assign FLAGS     = flags_r;

endmodule

// File: tb/tb_fp16_add_seq.sv
// Directed bench for fp16_add_seq: hand-computed results, flags, latency,
// back-pressure hold and asynchronous reset abort.
module tb_fp16_add_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_A;
  logic [15:0] IN_B;
  logic        IN_SUB;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] Q;
  logic [4:0]  FLAGS;

  int n_checks = 0;
  int n_errors = 0;

  fp16_add_seq #(.ALIGN_FAST(14)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_SUB(IN_SUB), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .Q(Q), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency counts clock edges after the accept edge up to the first edge that sees OUT_VALID.
  task automatic xact(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] eq, input logic [4:0] ef,
                      input int elat, input int hold);
    int lat;
    lat = 0;
    @(negedge CLK);
    for (int n = 0; n < 50 && IN_READY !== 1'b1; n++) @(negedge CLK);
    chk({tag, "_in_ready"}, IN_READY, 1);
    IN_A = a; IN_B = b; IN_SUB = sub; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_A = 16'hDEAD; IN_B = 16'hBEEF; IN_SUB = ~sub;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_q"}, Q, eq);
    chk({tag, "_flags"}, FLAGS, ef);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, "_hold_valid"}, OUT_VALID, 1);
      chk({tag, "_hold_q"}, Q, eq);
      chk({tag, "_hold_flags"}, FLAGS, ef);
      chk({tag, "_hold_in_ready"}, IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({tag, "_ready_after"}, IN_READY, 1);
    chk({tag, "_valid_after"}, OUT_VALID, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_SUB = 1'b0; OUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_q", Q, 16'h0000);
    chk("rst_flags", FLAGS, 5'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rel_in_ready", IN_READY, 1);

    //   tag           A        B        sub   Q        FLAGS     lat hold
    xact("one_one",    16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, 6,  0);
    xact("norm10",     16'h3C01, 16'h3C00, 1'b1, 16'h1400, 5'b00000, 15, 0);
    xact("overflow",   16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b00011, 6,  0);
    xact("fast_align", 16'h3C00, 16'h0001, 1'b0, 16'h3C00, 5'b00001, 6,  0);
    xact("inf_m_inf",  16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'b10000, 2,  0);
    xact("zero_bp",    16'h4500, 16'h4500, 1'b1, 16'h0000, 5'b01000, 6,  5);
    xact("one_half",   16'h3C00, 16'h3800, 1'b0, 16'h3E00, 5'b00000, 6,  0);
    xact("tie_even",   16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'b00001, 16, 0);
    xact("neg_zeros",  16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b01000, 6,  0);
    xact("nan_in",     16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000, 2,  0);
    xact("minus_inf",  16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 5'b00000, 2,  0);
    xact("sub_sum",    16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00000, 6,  0);
    xact("to_subnorm", 16'h0400, 16'h03FF, 1'b1, 16'h0001, 5'b00000, 6,  0);
    xact("tie_odd",    16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5'b00001, 16, 0);

    // Abort a long normalization with an asynchronous reset.
    @(negedge CLK);
    IN_A = 16'h3C01; IN_B = 16'h3C00; IN_SUB = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("abort_out_valid", OUT_VALID, 0);
    chk("abort_in_ready", IN_READY, 0);
    chk("abort_q", Q, 16'h0000);
    chk("abort_flags", FLAGS, 5'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("abort_rel_in_ready", IN_READY, 1);
    chk("abort_rel_out_valid", OUT_VALID, 0);
    xact("recover",    16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, 6,  0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
